// File: rtl/uart_cmd_parser.sv
// Line-oriented ASCII command parser: decodes "<letter>[hex digits]<CR|LF>" from a
// UART byte stream into an opcode plus hex argument, with optional byte echo.
module uart_cmd_parser #(
  parameter  int ARG_DIGITS = 8,
  parameter  int ECHO       = 1,
  localparam int AW         = 4 * ARG_DIGITS,
  localparam int DW         = $clog2(ARG_DIGITS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    rx_data,
  input  logic          rx_strobe,
  output logic [7:0]    echo_data,
  output logic          echo_strobe,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  output logic [7:0]    cmd_op,
  output logic [AW-1:0] cmd_arg,
  output logic [DW-1:0] cmd_digits,
  output logic          cmd_error,
  output logic          overrun
);

  typedef enum logic [1:0] {IDLE, ARGS, DISCARD, HOLD} StateT;

  StateT         r_state;
  StateT         w_nextState;
  logic [7:0]    r_cmdOp;
  logic [7:0]    w_nextOp;
  logic [AW-1:0] r_cmdArg;
  logic [AW-1:0] w_nextArg;
  logic [DW-1:0] r_cmdDigits;
  logic [DW-1:0] w_nextDigits;
  logic          r_cmdValid;
  logic [7:0]    r_echoData;
  logic          r_echoStrobe;
  logic          r_cmdError;
  logic          r_overrun;
  logic          w_echo;
  logic          w_error;
  logic          w_overrun;
  logic          w_isLetter;
  logic          w_isTerm;
  logic          w_isSpace;
  logic          w_isHex;
  logic [3:0]    w_nibble;

  always_comb begin
    w_isHex  = 1'b0;
    w_nibble = 4'd0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      w_isHex  = 1'b1;
      w_nibble = rx_data[3:0];
    end else if (rx_data >= 8'h61 && rx_data <= 8'h66) begin
      w_isHex  = 1'b1;
      w_nibble = rx_data[3:0] + 4'd9;
    end else if (rx_data >= 8'h41 && rx_data <= 8'h46) begin
      w_isHex  = 1'b1;
      w_nibble = rx_data[3:0] + 4'd9;
    end
  end

  assign w_isLetter = (rx_data >= 8'h61) && (rx_data <= 8'h7A);
  assign w_isTerm   = (rx_data == 8'h0D) || (rx_data == 8'h0A);
  assign w_isSpace  = (rx_data == 8'h20);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState  = r_state;
    w_nextOp     = r_cmdOp;
    w_nextArg    = r_cmdArg;
    w_nextDigits = r_cmdDigits;
    w_echo       = 1'b0;
    w_error      = 1'b0;
    w_overrun    = 1'b0;
    case (r_state)
      IDLE: if (rx_strobe) begin
        w_echo = 1'b1;
        if (w_isLetter) begin
          w_nextOp     = rx_data;
          w_nextArg    = '0;
          w_nextDigits = '0;
          w_nextState  = ARGS;
        end else if (!(w_isTerm || w_isSpace)) begin
          w_nextState = DISCARD;
        end
      end
      ARGS: if (rx_strobe) begin
        w_echo = 1'b1;
        if (w_isHex) begin
          if (r_cmdDigits == DW'(ARG_DIGITS)) begin
            w_nextState = DISCARD;
          end else begin
            w_nextArg    = (r_cmdArg << 4) | AW'(w_nibble);
            w_nextDigits = r_cmdDigits + DW'(1);
          end
        end else if (w_isTerm) begin
          w_nextState = HOLD;
        end else if (!w_isSpace) begin
          w_nextState = DISCARD;
        end
      end
      DISCARD: if (rx_strobe) begin
        w_echo = 1'b1;
        if (w_isTerm) begin
          w_error     = 1'b1;
          w_nextState = IDLE;
        end
      end
      HOLD: begin
        // Bytes arriving while a command is waiting cannot be buffered.
        w_overrun = rx_strobe;
        if (cmd_ready) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cmdOp      <= 8'd0;
      r_cmdArg     <= '0;
      r_cmdDigits  <= '0;
      r_cmdValid   <= 1'b0;
      r_echoData   <= 8'd0;
      r_echoStrobe <= 1'b0;
      r_cmdError   <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_cmdOp      <= w_nextOp;
      r_cmdArg     <= w_nextArg;
      r_cmdDigits  <= w_nextDigits;
      r_cmdValid   <= (w_nextState == HOLD);
      r_echoStrobe <= w_echo && (ECHO != 0);
      r_cmdError   <= w_error;
      r_overrun    <= w_overrun;
      if (w_echo) r_echoData <= rx_data;
    end
  end

  assign cmd_op      = r_cmdOp;
  assign cmd_arg     = r_cmdArg;
  assign cmd_digits  = r_cmdDigits;
  assign cmd_valid   = r_cmdValid;
  assign echo_data   = r_echoData;
  assign echo_strobe = r_echoStrobe;
  assign cmd_error   = r_cmdError;
  assign overrun     = r_overrun;

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

- Line-oriented ASCII command parser directly downstream of the USB UART receive path.
- Consumes the `rx_data`/`rx_strobe` byte stream and decodes lines of the form `<letter>[hex digits]<CR|LF>` into one opcode plus one hex argument.
- Presents each decoded command on a valid/ready interface to the command logic.
- Optionally echoes accepted bytes back toward the UART transmit side.

## Interface

Parameters:
- `ARG_DIGITS`, default 8: maximum hex digits per argument; `cmd_arg` width is 4*ARG_DIGITS.
- `ECHO`, default 1: 1 = echo accepted bytes on `echo_*`; 0 = `echo_strobe` tied low.

Ports:
- `clk`  in  1  single clock for the whole block.
- `reset`  in  1  asynchronous, active-low; block held in reset while 0.
- `rx_data`  in  8  received byte, valid when `rx_strobe`.
- `rx_strobe`  in  1  one-cycle byte strobe; back-to-back cycles allowed; no backpressure.
- `echo_data`  out  8  echoed byte.
- `echo_strobe`  out  1  one-cycle echo strobe, feeds the UART `tx_strobe`.
- `cmd_valid`  out  1  decoded command held valid.
- `cmd_ready`  in  1  consumer accepts the command.
- `cmd_op`  out  8  opcode letter, ASCII `a`..`z`.
- `cmd_arg`  out  4*ARG_DIGITS  argument, right-aligned, zero-extended.
- `cmd_digits`  out  $clog2(ARG_DIGITS+1)  number of hex digits received (0 allowed).
- `cmd_error`  out  1  one-cycle pulse when a malformed line is terminated.
- `overrun`  out  1  one-cycle pulse when a byte is dropped.

## Operation

- Terminator = CR (0x0D) or LF (0x0A). Hex digit = `0-9`, `a-f`, `A-F`. Space = 0x20.
- States: IDLE, ARGS, DISCARD, HOLD. Bytes are processed only on cycles with `rx_strobe`=1.
- IDLE:
  - `a`..`z`: latch `cmd_op`, clear arg and digits, go to ARGS.
  - Terminator or space: stay in IDLE; no error (empty lines are silent).
  - Anything else: go to DISCARD.
- ARGS:
  - Hex digit with digits < ARG_DIGITS: arg = (arg<<4) | nibble, digits+1.
  - Hex digit with digits == ARG_DIGITS: go to DISCARD.
  - Space: ignored anywhere in the line.
  - Terminator: go to HOLD.
  - Anything else: go to DISCARD.
- DISCARD:
  - Terminator: pulse `cmd_error`, go to IDLE.
  - Anything else: stay in DISCARD.
- HOLD:
  - `cmd_valid`=1; `cmd_op`, `cmd_arg`, `cmd_digits` stable.
  - `cmd_ready`=1: deassert `cmd_valid` next cycle, go to IDLE.
  - Any `rx_strobe` in HOLD, including the cycle `cmd_ready` is high: byte dropped, not echoed, `overrun` pulses.
- Echo (ECHO=1): every byte processed in IDLE/ARGS/DISCARD is echoed verbatim. `echo_data` holds the last echoed byte.
- Reset mid-line: partial line lost silently; no `cmd_error`, no `cmd_valid`.

## Timing

- All outputs registered.
- Reset values: `echo_data`=0, `echo_strobe`=0, `cmd_valid`=0, `cmd_op`=0, `cmd_arg`=0, `cmd_digits`=0, `cmd_error`=0, `overrun`=0. State = IDLE.
- `echo_strobe`/`echo_data`: cycle N+1 after a byte strobed at cycle N; back-to-back input gives back-to-back echo.
- `cmd_valid`: rises cycle N+1 after the terminator at cycle N.
- `cmd_error` and `overrun`: pulse at cycle N+1 after the triggering byte.
- Handshake: transfer occurs on a cycle with `cmd_valid`&`cmd_ready`.
  - Payload must not change while `cmd_valid` is high.
  - `cmd_ready` while `cmd_valid`=0 is ignored.
- Earliest next command: the first byte strobed one cycle after the transfer cycle is processed normally in IDLE.

## Test plan

- Normal command: `r1234\r` back-to-back -> `cmd_valid` one cycle after CR; `cmd_op`=0x72, `cmd_arg`=0x1234, `cmd_digits`=4; 6 echo strobes with identical bytes.
- Spaces and uppercase: `w 00aB CD\n` -> `cmd_op`=0x77, `cmd_arg`=0x00ABCD, `cmd_digits`=6; `z\n` -> `cmd_arg`=0, `cmd_digits`=0.
- Overflow and invalid characters:
  - `a123456789\r` (9 digits, ARG_DIGITS=8) -> no `cmd_valid`; one `cmd_error` pulse after CR.
  - `q12g\n` -> one `cmd_error` pulse after LF.
  - `\r\n` alone -> nothing.
- Backpressure: hold `cmd_ready`=0 for 20 cycles after `x5\r`, strobe `y` during HOLD -> `cmd_arg`=5 stable throughout; `overrun` pulses once; no echo of `y`; `cmd_valid` drops the cycle after `cmd_ready`=1.
- Asynchronous reset: assert `reset`=0 mid-line after `r12`, then release and send `s7\r` -> all outputs 0 during reset; no error; next command `cmd_op`=0x73, `cmd_arg`=7, `cmd_digits`=1.
- ECHO=0 build: `r1\r` -> `echo_strobe` never asserts; command decoded identically.
